// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS load/store bus initiator.
//   size_e  : access size encoding carried on cmd_size
//   state_e : initiator FSM states
//   access_illegal() : flags reserved sizes and misaligned half/word accesses
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic access_illegal(input size_e size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lo[0];
      SIZE_WORD: bad = (lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_bus_lane_align.sv
// Combinational lane steering for the bus initiator.
//   Store side: st_size/st_lane/st_wdata -> st_byteenable, st_writedata
//               (store data replicated across lanes; byteenable picks lanes)
//   Load side : ld_size/ld_lane/ld_signed/ld_readdata -> ld_rdata
//               (selected lane(s) right-justified, then sign/zero extended)
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byteenable,
  output logic [31:0] st_writedata,
  input  size_e       ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_signed,
  input  logic [31:0] ld_readdata,
  output logic [31:0] ld_rdata
);

  always_comb begin
    st_byteenable = '0;
    st_writedata  = '0;
    case (st_size)
      SIZE_BYTE: begin
        st_byteenable = 4'b0001 << st_lane;
        st_writedata  = {4{st_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_byteenable = st_lane[1] ? 4'b1100 : 4'b0011;
        st_writedata  = {2{st_wdata[15:0]}};
      end
      SIZE_WORD: begin
        st_byteenable = 4'b1111;
        st_writedata  = st_wdata;
      end
      default: begin
        st_byteenable = '0;
        st_writedata  = '0;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = '0;
    case (ld_lane)
      2'd0: ld_byte = ld_readdata[7:0];
      2'd1: ld_byte = ld_readdata[15:8];
      2'd2: ld_byte = ld_readdata[23:16];
      default: ld_byte = ld_readdata[31:24];
    endcase
    ld_half = ld_lane[1] ? ld_readdata[31:16] : ld_readdata[15:0];

    ld_rdata = '0;
    case (ld_size)
      SIZE_BYTE: ld_rdata = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_rdata = {{16{ld_signed & ld_half[15]}}, ld_half};
      SIZE_WORD: ld_rdata = ld_readdata;
      default:   ld_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mips_bus_initiator.sv
// Load/store command to single-beat bus initiator.
//   clk, reset (async, active-low)
//   cmd_*  : command handshake (valid/ready) with write, addr, size, signed, wdata
//   rsp_*  : response handshake (valid/ready) with rdata and err
//   address, read, write, writedata, byteenable, waitrequest, readdata : bus side
// Illegal commands respond with err and never touch the bus. A bus access that
// stalls TIMEOUT_CYCLES edges is aborted with err.
module mips_bus_initiator
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_signed,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  size_e            size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic             signed_q, signed_d;
  logic [31:0]      address_q, address_d;
  logic [31:0]      writedata_q, writedata_d;
  logic [3:0]       byteenable_q, byteenable_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [3:0]  st_byteenable;
  logic [31:0] st_writedata;
  logic [31:0] ld_rdata;

  mips_bus_lane_align u_lane_align (
    .st_size       (size_e'(cmd_size)),
    .st_lane       (cmd_addr[1:0]),
    .st_wdata      (cmd_wdata),
    .st_byteenable (st_byteenable),
    .st_writedata  (st_writedata),
    .ld_size       (size_q),
    .ld_lane       (lane_q),
    .ld_signed     (signed_q),
    .ld_readdata   (readdata),
    .ld_rdata      (ld_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      size_q       <= SIZE_BYTE;
      lane_q       <= '0;
      signed_q     <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      signed_q     <= signed_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    lane_d       = lane_q;
    signed_d     = signed_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (access_illegal(size_e'(cmd_size), cmd_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d      = ST_BUS;
            cnt_d        = '0;
            wr_d         = cmd_write;
            size_d       = size_e'(cmd_size);
            lane_d       = cmd_addr[1:0];
            signed_d     = cmd_signed;
            address_d    = {cmd_addr[31:2], 2'b00};
            writedata_d  = st_writedata;
            byteenable_d = st_byteenable;
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = wr_q ? '0 : ld_rdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // This stall edge brings the count to TIMEOUT_CYCLES: abort.
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Qualifying with reset keeps the command port closed while reset is held.
  assign cmd_ready  = (state_q == ST_IDLE) && reset;
  assign read       = (state_q == ST_BUS) && !wr_q;
  assign write      = (state_q == ST_BUS) && wr_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_bus_initiator.sv
module tb_mips_bus_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [1:0]  cmd_size = '0;
  logic        cmd_signed = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  mips_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_signed  (cmd_signed),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each response at the handshake.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      logic [32:0] e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual=%h/%0b required=none", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[32:1]);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
      end
    end
  end

  // Issues one command starting at posedge+1, acts as the bus responder with
  // `stalls` waitrequest edges, and consumes the response after `hold` cycles.
  task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                         input logic [31:0] rdin, input int stalls, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input int exp_cnt,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int stl, cnt, guard;
    logic [31:0] held;
    logic [31:0] mask;
    stl = stalls;
    waitrequest = (stl > 0);
    readdata = rdin;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size;
    cmd_signed = sgn; cmd_wdata = wdata;
    exp_q.push_back({exp_rdata, exp_err});
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    check({name, "_accept"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    cnt = 0; guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      if (!(read || write)) break;
      cnt++;
      if (cnt == 1) begin
        mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
        check({name, "_strobe"}, {30'd0, write, read}, wr ? 32'd2 : 32'd1);
        check({name, "_address"}, address, {addr[31:2], 2'b00});
        check({name, "_byteenable"}, {28'd0, byteenable}, {28'd0, exp_be});
        if (wr) check({name, "_writedata"}, writedata & mask, exp_wd & mask);
      end
      @(posedge clk); #1;
      if (stl > 0) stl--;
      waitrequest = (stl > 0);
      guard++;
    end
    check({name, "_strobe_cycles"}, cnt, exp_cnt);
    check({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check({name, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({name, "_hold_rdata"}, rsp_rdata, held);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    waitrequest = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_byteenable", {28'd0, byteenable}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    //       name      wr    addr          sz  sg  wdata          readdata       st  be       wd             cnt exp_rdata     err  hold
    run_txn("ldw",     1'b0, 32'hBFC00004, 2, 1'b0, 32'h0,        32'h11223344,  0, 4'b1111, 32'h0,          1, 32'h11223344, 1'b0, 0);
    run_txn("lbs",     1'b0, 32'hBFC00003, 0, 1'b1, 32'h0,        32'h80FFFFFF,  0, 4'b1000, 32'h0,          1, 32'hFFFFFF80, 1'b0, 0);
    run_txn("lbu",     1'b0, 32'hBFC00003, 0, 1'b0, 32'h0,        32'h80FFFFFF,  0, 4'b1000, 32'h0,          1, 32'h00000080, 1'b0, 0);
    run_txn("sh",      1'b1, 32'h00001002, 1, 1'b0, 32'h0000ABCD, 32'h0,         3, 4'b1100, 32'hABCD0000,   4, 32'h0,        1'b0, 0);
    run_txn("ldw_mis", 1'b0, 32'h00001001, 2, 1'b0, 32'h0,        32'h12345678,  0, 4'b0000, 32'h0,          0, 32'h0,        1'b1, 0);
    run_txn("tmo",     1'b0, 32'h00002000, 2, 1'b0, 32'h0,        32'hDEADBEEF, 1000, 4'b1111, 32'h0,        8, 32'h0,        1'b1, 0);
    run_txn("sb",      1'b1, 32'h00001001, 0, 1'b0, 32'h0000005A, 32'h0,         0, 4'b0010, 32'h00005A00,   1, 32'h0,        1'b0, 0);
    run_txn("lhs",     1'b0, 32'h00002000, 1, 1'b1, 32'h0,        32'h12348001,  0, 4'b0011, 32'h0,          1, 32'hFFFF8001, 1'b0, 0);
    run_txn("lhu",     1'b0, 32'h00002002, 1, 1'b0, 32'h0,        32'h80011234,  0, 4'b1100, 32'h0,          1, 32'h00008001, 1'b0, 0);
    run_txn("rsvd",    1'b0, 32'h00003000, 3, 1'b0, 32'h0,        32'h0,         0, 4'b0000, 32'h0,          0, 32'h0,        1'b1, 0);
    run_txn("sh_mis",  1'b1, 32'h00000003, 1, 1'b0, 32'h00001111, 32'h0,         0, 4'b0000, 32'h0,          0, 32'h0,        1'b1, 0);
    run_txn("sw",      1'b1, 32'h00000004, 2, 1'b0, 32'hCAFEF00D, 32'h0,         1, 4'b1111, 32'hCAFEF00D,   2, 32'h0,        1'b0, 0);
    run_txn("lb1",     1'b0, 32'h00000001, 0, 1'b1, 32'h0,        32'h00007F00,  0, 4'b0010, 32'h0,          1, 32'h0000007F, 1'b0, 0);
    run_txn("hold",    1'b0, 32'h00004008, 2, 1'b0, 32'h0,        32'h0BADF00D,  0, 4'b1111, 32'h0,          1, 32'h0BADF00D, 1'b0, 5);

    // Reset while a load is stalled on the bus: no response may follow.
    waitrequest = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h00005000; cmd_size = 2'd2; cmd_signed = 1'b0;
    @(negedge clk);
    check("mid_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_read_high", {31'd0, read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_strobes", {30'd0, read, write}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_address", address, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("post_rst_no_rsp", {30'd0, rsp_valid, read}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_initiator.md
MIPS_BUS_INITIATOR -- requirements
Module: mips_bus_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max waitrequest-high cycles before a bus abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 cmd_write  input  1  1 = store, 0 = load.
REQ-007 cmd_addr  input  32  byte address.
REQ-008 cmd_size  input  2  access size, 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-009 cmd_signed  input  1  load sign-extend (1) or zero-extend (0).
REQ-010 cmd_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned, reserved size, or timeout.
REQ-015 address  output  32  bus address, {cmd_addr[31:2], 2'b00}.
REQ-016 read / write  output  1 each  bus strobes; never both high.
REQ-017 writedata  output  32  lane-shifted store data.
REQ-018 byteenable  output  4  byteenable[i] selects bits [8i+7:8i], little-endian.
REQ-019 waitrequest  input  1  responder stall.
REQ-020 readdata  input  32  valid in the cycle read=1 and waitrequest=0.

Function
REQ-021 FSM states: IDLE, BUS, RESP.
REQ-022 IDLE: cmd_ready=1; all bus strobes are low.
REQ-023 IDLE, accepting a legal command: latch the command, go to BUS.
REQ-024 IDLE, accepting an illegal command: go straight to RESP with rsp_err=1, no bus cycle.
- Illegal: size 3; half with addr[0]=1; word with addr[1:0]!=0.
REQ-025 BUS: read or write held high; address, writedata and byteenable held stable.
REQ-026 BUS, edge with waitrequest=0: transaction completes, capture readdata, go to RESP.
REQ-027 BUS stall: a counter increments on each edge with waitrequest=1.
REQ-028 BUS timeout: on the edge where the counter reaches TIMEOUT_CYCLES, drop strobes, go to RESP with rsp_err=1.
REQ-029 RESP: rsp_valid=1, outputs stable; on rsp_ready go to IDLE; cmd_ready=0 in BUS and RESP.
REQ-030 Latency: accept edge -> BUS for >=1 cycle -> rsp_valid asserted 2 cycles after acceptance when waitrequest=0.
REQ-031 Lanes: byte -> enable 1<<addr[1:0], data replicated to all lanes; half -> 4'b0011 or 4'b1100; word -> 4'b1111.
REQ-032 Load extract: the selected lane(s) of readdata, right-justified, then sign- or zero-extended to 32 bits.
REQ-033 Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it clears on entry to BUS.

Reset
REQ-034 On reset=0: state IDLE, read=write=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, address=0, writedata=0, byteenable=0, counter=0; cmd_ready=0 while reset is asserted.
REQ-035 Reset mid-BUS: strobes drop asynchronously; the in-flight command is discarded with no response.

Structure
REQ-036 Package mips_bus_pkg holds the size encodings and the FSM state enum.
REQ-037 Combinational sub-module mips_bus_lane_align holds lane/byteenable generation and load extraction/extension.

Verification
REQ-038 Word load, addr 0xBFC00004, waitrequest=0, readdata 0x11223344 -> rsp_rdata 0x11223344 2 cycles after accept, err=0.
REQ-039 Signed byte load, addr 0xBFC00003, readdata 0x80FFFFFF -> byteenable 4'b1000, rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Half store, addr 0x1002, wdata 0xABCD, waitrequest high 3 cycles -> write held 4 cycles, byteenable 4'b1100, writedata[31:16]=0xABCD.
REQ-041 Word load at addr 0x1001 -> no read strobe, rsp_err=1, rsp_rdata=0 one cycle after accept.
REQ-042 waitrequest stuck high, TIMEOUT_CYCLES=8 -> strobe drops after 8 stall edges, rsp_err=1.
REQ-043 rsp_ready held low 5 cycles, then reset asserted in BUS -> response held stable for those 5 cycles; after reset, strobes low immediately and state IDLE.
